// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus multiplexer with a built-in arbiter (fixed priority or round-robin).
// It reports the grant, whether several sources requested at once, and a saturating contention count.
module bus_arbiter_mux #(
   parameter int  WIDTH     = 32,
   parameter int  NUM_SRC   = 24,
   parameter int  RR_MODE   = 0,
   parameter int  HOLD_LAST = 1,
   localparam int SEL_W     = $clog2(NUM_SRC)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NUM_SRC*WIDTH-1:0] src_data,
   input  logic [NUM_SRC-1:0]       src_req,
   input  logic                     bus_en,
   input  logic                     clr_cnt,
   output logic [WIDTH-1:0]         bus_data,
   output logic                     bus_valid,
   output logic [NUM_SRC-1:0]       grant_oh,
   output logic [SEL_W-1:0]         grant_idx,
   output logic                     contention,
   output logic [15:0]              contention_cnt
);

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [WIDTH-1:0]   bus_data_q,   bus_data_d;
   logic               bus_valid_q,  bus_valid_d;
   logic [NUM_SRC-1:0] grant_oh_q,   grant_oh_d;
   logic [SEL_W-1:0]   grant_idx_q,  grant_idx_d;
   logic               contention_q, contention_d;
   logic [15:0]        cnt_q,        cnt_d;
   logic [SEL_W-1:0]   ptr_q,        ptr_d;

   logic               win_found;
   logic [SEL_W-1:0]   win_idx;
   logic [NUM_SRC-1:0] win_oh;
   logic [WIDTH-1:0]   win_data;
   logic               multi_req;

   // Clearing the lowest set bit leaves something only when two or more bits were set.
   assign multi_req = |(src_req & (src_req - NUM_SRC'(1)));

   // The search starts just past the pointer in round-robin mode, or at index 0 in fixed mode.
   always_comb begin : arb_comb
      int cand;
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      win_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = (RR_MODE != 0) ? (int'(ptr_q) + 1 + i) % NUM_SRC : i;
         if (!win_found && src_req[cand]) begin
            win_found    = 1'b1;
            win_idx      = SEL_W'(cand);
            win_oh[cand] = 1'b1;
            win_data     = src_data[cand*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      bus_data_d   = bus_data_q;
      bus_valid_d  = bus_valid_q;
      grant_oh_d   = grant_oh_q;
      grant_idx_d  = grant_idx_q;
      contention_d = contention_q;
      cnt_d        = cnt_q;
      ptr_d        = ptr_q;
      if (bus_en) begin
         contention_d = multi_req;
         if (multi_req && cnt_q != CNT_MAX) cnt_d = cnt_q + 16'd1;
         if (win_found) begin
            bus_data_d  = win_data;
            bus_valid_d = 1'b1;
            grant_oh_d  = win_oh;
            grant_idx_d = win_idx;
            ptr_d       = win_idx;
         end else begin
            bus_valid_d = 1'b0;
            grant_oh_d  = '0;
            if (HOLD_LAST == 0) bus_data_d = '0;
         end
      end
      // A clear overrides an increment in the same cycle, even during a stall.
      if (clr_cnt) cnt_d = '0;
   end

   // NOTE: non-blocking assignments so every register updates from values sampled before the edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_data_q   <= '0;
         bus_valid_q  <= 1'b0;
         grant_oh_q   <= '0;
         grant_idx_q  <= '0;
         contention_q <= 1'b0;
         cnt_q        <= '0;
         ptr_q        <= SEL_W'(NUM_SRC - 1);
      end else begin
         bus_data_q   <= bus_data_d;
         bus_valid_q  <= bus_valid_d;
         grant_oh_q   <= grant_oh_d;
         grant_idx_q  <= grant_idx_d;
         contention_q <= contention_d;
         cnt_q        <= cnt_d;
         ptr_q        <= ptr_d;
      end
   end

   assign bus_data       = bus_data_q;
   assign bus_valid      = bus_valid_q;
   assign grant_oh       = grant_oh_q;
   assign grant_idx      = grant_idx_q;
   assign contention     = contention_q;
   assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: a fixed-priority/HOLD_LAST instance and a round-robin/zero-idle
// instance share the same stimulus, so both variants are checked against hand-computed vectors.
module tb_bus_arbiter_mux;

   localparam int WIDTH   = 32;
   localparam int NUM_SRC = 24;
   localparam int SEL_W   = 5;
   localparam int NVEC    = 13;

   logic                     clock = 1'b0;
   logic                     reset_n;
   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [NUM_SRC-1:0]       src_req;
   logic                     bus_en;
   logic                     clr_cnt;

   logic [WIDTH-1:0]   fx_data,  rr_data;
   logic               fx_valid, rr_valid;
   logic [NUM_SRC-1:0] fx_oh,    rr_oh;
   logic [SEL_W-1:0]   fx_idx,   rr_idx;
   logic               fx_cont,  rr_cont;
   logic [15:0]        fx_cnt,   rr_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   bus_arbiter_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .RR_MODE(0), .HOLD_LAST(1)) u_fx (
      .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_req(src_req),
      .bus_en(bus_en), .clr_cnt(clr_cnt), .bus_data(fx_data), .bus_valid(fx_valid),
      .grant_oh(fx_oh), .grant_idx(fx_idx), .contention(fx_cont), .contention_cnt(fx_cnt)
   );

   bus_arbiter_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .RR_MODE(1), .HOLD_LAST(0)) u_rr (
      .clock(clock), .reset_n(reset_n), .src_data(src_data), .src_req(src_req),
      .bus_en(bus_en), .clr_cnt(clr_cnt), .bus_data(rr_data), .bus_valid(rr_valid),
      .grant_oh(rr_oh), .grant_idx(rr_idx), .contention(rr_cont), .contention_cnt(rr_cnt)
   );

   typedef struct {
      logic [NUM_SRC-1:0] req;
      logic               en;
      logic               clr;
      logic               fx_v;
      int                 fx_i;
      logic [WIDTH-1:0]   fx_d;
      logic               rr_v;
      int                 rr_i;
      logic [WIDTH-1:0]   rr_d;
      logic               cont;
      logic [15:0]        cnt;
   } vec_t;

   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [NUM_SRC-1:0] oh_of(input logic v, input int idx);
      logic [NUM_SRC-1:0] one;
      one = 1;
      return v ? (one << idx) : '0;
   endfunction

   task automatic check_all(input string tag,
                            input logic fv, input int fi, input logic [WIDTH-1:0] fd,
                            input logic rv, input int ri, input logic [WIDTH-1:0] rd,
                            input logic ct, input logic [15:0] cn);
      check({tag, " fx_valid"}, 64'(fx_valid), 64'(fv));
      check({tag, " fx_idx"},   64'(fx_idx),   64'(fi));
      check({tag, " fx_data"},  64'(fx_data),  64'(fd));
      check({tag, " fx_oh"},    64'(fx_oh),    64'(oh_of(fv, fi)));
      check({tag, " fx_cont"},  64'(fx_cont),  64'(ct));
      check({tag, " fx_cnt"},   64'(fx_cnt),   64'(cn));
      check({tag, " fx_inv"},   64'({fx_valid == (|fx_oh), $onehot0(fx_oh)}), 64'(2'b11));
      check({tag, " rr_valid"}, 64'(rr_valid), 64'(rv));
      check({tag, " rr_idx"},   64'(rr_idx),   64'(ri));
      check({tag, " rr_data"},  64'(rr_data),  64'(rd));
      check({tag, " rr_oh"},    64'(rr_oh),    64'(oh_of(rv, ri)));
      check({tag, " rr_cont"},  64'(rr_cont),  64'(ct));
      check({tag, " rr_cnt"},   64'(rr_cnt),   64'(cn));
      check({tag, " rr_inv"},   64'({rr_valid == (|rr_oh), $onehot0(rr_oh)}), 64'(2'b11));
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] word(input int i);
      return {16'hDEAD, 16'(i)};
   endfunction

   initial begin
      for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = word(i);

      // Expected values worked by hand; the RR pointer starts at 23 after reset.
      vecs[0]  = '{24'h100088, 1, 0, 1,  3, 32'hDEAD0003, 1,  3, 32'hDEAD0003, 1, 16'd1};
      vecs[1]  = '{24'h800000, 1, 0, 1, 23, 32'hDEAD0017, 1, 23, 32'hDEAD0017, 0, 16'd1};
      vecs[2]  = '{24'h000000, 1, 0, 0, 23, 32'hDEAD0017, 0, 23, 32'h00000000, 0, 16'd1};
      vecs[3]  = '{24'h000003, 0, 0, 0, 23, 32'hDEAD0017, 0, 23, 32'h00000000, 0, 16'd1};
      vecs[4]  = '{24'hFFFFFF, 0, 0, 0, 23, 32'hDEAD0017, 0, 23, 32'h00000000, 0, 16'd1};
      vecs[5]  = '{24'hFFFFFF, 1, 0, 1,  0, 32'hDEAD0000, 1,  0, 32'hDEAD0000, 1, 16'd2};
      vecs[6]  = '{24'h000060, 1, 1, 1,  5, 32'hDEAD0005, 1,  5, 32'hDEAD0005, 1, 16'd0};
      vecs[7]  = '{24'h000300, 1, 0, 1,  8, 32'hDEAD0008, 1,  8, 32'hDEAD0008, 1, 16'd1};
      vecs[8]  = '{24'h000004, 0, 1, 1,  8, 32'hDEAD0008, 1,  8, 32'hDEAD0008, 1, 16'd0};
      vecs[9]  = '{24'h001000, 1, 0, 1, 12, 32'hDEAD000C, 1, 12, 32'hDEAD000C, 0, 16'd0};
      vecs[10] = '{24'h009000, 1, 0, 1, 12, 32'hDEAD000C, 1, 15, 32'hDEAD000F, 1, 16'd1};
      vecs[11] = '{24'h009000, 1, 0, 1, 12, 32'hDEAD000C, 1, 12, 32'hDEAD000C, 1, 16'd2};
      vecs[12] = '{24'h800001, 1, 0, 1,  0, 32'hDEAD0000, 1, 23, 32'hDEAD0017, 1, 16'd3};

      reset_n = 1'b0;
      src_req = '1;
      bus_en  = 1'b1;
      clr_cnt = 1'b0;
      step();
      step();
      check_all("reset", 0, 0, '0, 0, 0, '0, 0, 16'd0);
      src_req = '0;
      reset_n = 1'b1;

      for (int v = 0; v < NVEC; v++) begin
         src_req = vecs[v].req;
         bus_en  = vecs[v].en;
         clr_cnt = vecs[v].clr;
         step();
         check_all($sformatf("v%0d", v), vecs[v].fx_v, vecs[v].fx_i, vecs[v].fx_d,
                   vecs[v].rr_v, vecs[v].rr_i, vecs[v].rr_d, vecs[v].cont, vecs[v].cnt);
      end

      // Asynchronous reset in the middle of a busy stream clears everything without a clock edge.
      src_req = '1;
      bus_en  = 1'b1;
      clr_cnt = 1'b0;
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      check_all("midreset", 0, 0, '0, 0, 0, '0, 0, 16'd0);
      step();
      check_all("inreset", 0, 0, '0, 0, 0, '0, 0, 16'd0);
      reset_n = 1'b1;

      // Round-robin rotation from a fresh pointer with every source requesting.
      for (int k = 0; k < 26; k++) begin
         step();
         check_all($sformatf("rr%0d", k), 1, 0, word(0), 1, k % NUM_SRC, word(k % NUM_SRC),
                   1, 16'(k + 1));
      end

      // Saturation of the contention counter.
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      src_req = 24'h000005;
      for (int k = 0; k < 65535; k++) step();
      check("sat fx_cnt", 64'(fx_cnt), 64'hFFFF);
      check("sat rr_cnt", 64'(rr_cnt), 64'hFFFF);
      step();
      step();
      check("nowrap fx_cnt", 64'(fx_cnt), 64'hFFFF);
      check("nowrap rr_cnt", 64'(rr_cnt), 64'hFFFF);
      clr_cnt = 1'b1;
      step();
      check("clr fx_cnt", 64'(fx_cnt), 64'h0);
      check("clr rr_cnt", 64'(rr_cnt), 64'h0);
      check("clr fx_cont", 64'(fx_cont), 64'h1);
      clr_cnt = 1'b0;
      step();
      check("after clr fx_cnt", 64'(fx_cnt), 64'h1);
      check("after clr rr_cnt", 64'(rr_cnt), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
